// File: rtl/matmul_sequencer.sv
// Job sequencer for one systolic matrix multiply: operand latch, PE clear,
// feed supervision with timeout, drain wait, result capture and hand-off.
module matmul_sequencer #(
  parameter int MATRIX_SIZE  = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int ACC_WIDTH    = 20,
  parameter int DRAIN_CYCLES = 4,
  parameter int FEED_TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start_valid,
  output logic start_ready,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] mat_a_in,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] mat_b_in,
  output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] mat_a_out,
  output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] mat_b_out,
  output logic feed_rst,
  input  logic feed_done_a,
  input  logic feed_done_b,
  output logic tpu_clear,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*ACC_WIDTH-1:0] tpu_result_in,
  output logic [MATRIX_SIZE*MATRIX_SIZE*ACC_WIDTH-1:0] result_out,
  output logic result_valid,
  input  logic result_ready,
  output logic result_err,
  output logic busy
);

  localparam int OW = MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH;
  localparam int RW = MATRIX_SIZE*MATRIX_SIZE*ACC_WIDTH;
  localparam int FW = $clog2(FEED_TIMEOUT);
  localparam int DW = $clog2(DRAIN_CYCLES+1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_FEED    = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_OUT     = 3'd5;

  logic [2:0]    r_state;
  logic [FW-1:0] r_feed_cnt;
  logic [DW-1:0] r_drain_cnt;
  logic          r_done_a;
  logic          r_done_b;
  logic          r_err;
  logic [OW-1:0] r_a;
  logic [OW-1:0] r_b;
  logic [RW-1:0] r_result;
  logic          r_result_err;

  logic w_done_a;
  logic w_done_b;
  logic w_both;
  logic w_timeout;
  logic w_drain_end;

  // A pulse landing in the same cycle as the other flag still counts.
  assign w_done_a    = r_done_a | feed_done_a;
  assign w_done_b    = r_done_b | feed_done_b;
  assign w_both      = w_done_a & w_done_b;
  assign w_timeout   = (r_feed_cnt == FW'(FEED_TIMEOUT-1));
  assign w_drain_end = (r_drain_cnt == DW'(DRAIN_CYCLES-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_feed_cnt   <= '0;
      r_drain_cnt  <= '0;
      r_done_a     <= 1'b0;
      r_done_b     <= 1'b0;
      r_err        <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_result     <= '0;
      r_result_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_a     <= mat_a_in;
            r_b     <= mat_b_in;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_feed_cnt <= '0;
          r_done_a   <= 1'b0;
          r_done_b   <= 1'b0;
          r_state    <= S_FEED;
        end
        S_FEED: begin
          r_done_a <= w_done_a;
          r_done_b <= w_done_b;
          if (w_both) begin
            r_drain_cnt <= '0;
            r_state     <= S_DRAIN;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_CAPTURE;
          end else begin
            r_feed_cnt <= r_feed_cnt + FW'(1);
          end
        end
        S_DRAIN: begin
          if (w_drain_end) r_state <= S_CAPTURE;
          else r_drain_cnt <= r_drain_cnt + DW'(1);
        end
        S_CAPTURE: begin
          r_result     <= tpu_result_in;
          r_result_err <= r_err;
          r_state      <= S_OUT;
        end
        S_OUT: begin
          if (result_ready) begin
            r_feed_cnt  <= '0;
            r_drain_cnt <= '0;
            r_done_a    <= 1'b0;
            r_done_b    <= 1'b0;
            r_err       <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign start_ready  = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign feed_rst     = (r_state != S_FEED);
  assign tpu_clear    = (r_state == S_CLEAR);
  assign result_valid = (r_state == S_OUT);
  assign result_out   = r_result;
  assign result_err   = r_result_err;
  assign mat_a_out    = r_a;
  assign mat_b_out    = r_b;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: padding-engine/PE-array stand-in, a job-level
// timing model checked every cycle, and directed jobs with literal results.
module tb_matmul_sequencer;

  localparam int N  = 4;
  localparam int N2 = N*N;
  localparam int DW = 8;
  localparam int AW = 20;
  localparam int OW = N2*DW;
  localparam int RW = N2*AW;
  localparam int DRAIN = 4;
  localparam int TMO = 32;

  logic clk = 1'b0;
  logic rst;
  logic start_valid;
  logic start_ready;
  logic [OW-1:0] mat_a_in, mat_b_in, mat_a_out, mat_b_out;
  logic feed_rst, feed_done_a, feed_done_b, tpu_clear;
  logic [RW-1:0] tpu_result_in, result_out;
  logic result_valid, result_ready, result_err, busy;

  int checks = 0;
  int failures = 0;
  int eng_da = 10;
  int eng_db = 10;
  int clr_cnt = 0;

  matmul_sequencer dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .mat_a_in(mat_a_in), .mat_b_in(mat_b_in),
    .mat_a_out(mat_a_out), .mat_b_out(mat_b_out),
    .feed_rst(feed_rst),
    .feed_done_a(feed_done_a), .feed_done_b(feed_done_b),
    .tpu_clear(tpu_clear), .tpu_result_in(tpu_result_in),
    .result_out(result_out), .result_valid(result_valid),
    .result_ready(result_ready), .result_err(result_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [RW-1:0] act,
                     input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] matmul(input logic [OW-1:0] a,
                                           input logic [OW-1:0] b);
    logic [RW-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++)
          s += int'(a[(N2-1-(i*N+k))*DW +: DW]) *
               int'(b[(N2-1-(k*N+j))*DW +: DW]);
        r[(N2-1-(i*N+j))*AW +: AW] = AW'(s);
      end
    return r;
  endfunction

  function automatic logic [OW-1:0] ident(input int sc);
    logic [OW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[(N2-1-(i*N+i))*DW +: DW] = DW'(sc);
    return r;
  endfunction

  // Element e = off + dir*e (dir=+1 ascending, -1 descending)
  function automatic logic [OW-1:0] seq8(input int off, input int dir);
    logic [OW-1:0] r;
    for (int e = 0; e < N2; e++) r[(N2-1-e)*DW +: DW] = DW'(off + dir*e);
    return r;
  endfunction

  function automatic logic [RW-1:0] seq20(input int off, input int dir,
                                          input int sc);
    logic [RW-1:0] r;
    for (int e = 0; e < N2; e++) r[(N2-1-e)*AW +: AW] = AW'(sc*(off + dir*e));
    return r;
  endfunction

  // Padding engines + PE array stand-in
  int ec = 0;
  initial begin
    feed_done_a = 1'b0;
    feed_done_b = 1'b0;
    tpu_result_in = '0;
    forever begin
      @(posedge clk); #1;
      if (feed_rst) ec = 0; else ec++;
      feed_done_a = (ec != 0 && ec == eng_da);
      feed_done_b = (ec != 0 && ec == eng_db);
      if (tpu_clear) tpu_result_in = '0;
      if (ec != 0 && eng_da != 0 && eng_db != 0 &&
          ec == ((eng_da > eng_db) ? eng_da : eng_db))
        tpu_result_in = matmul(mat_a_out, mat_b_out);
    end
  end

  always @(negedge clk) if (tpu_clear === 1'b1) clr_cnt++;

  // Job-level model: phase of the current job from cycles since accept
  bit m_busy = 0;
  int m_t, m_f, m_v;
  bit m_to;
  logic [OW-1:0] m_a, m_b;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_start_ready", start_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_feed_rst", feed_rst, 1);
      chk("rst_tpu_clear", tpu_clear, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_result_err", result_err, 0);
      chk("rst_result_out", result_out, 0);
      chk("rst_mat_a_out", mat_a_out, 0);
      chk("rst_mat_b_out", mat_b_out, 0);
      m_busy = 0;
    end else if (!m_busy) begin
      chk("idle_start_ready", start_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_feed_rst", feed_rst, 1);
      chk("idle_tpu_clear", tpu_clear, 0);
      chk("idle_result_valid", result_valid, 0);
      if (start_valid) begin
        m_busy = 1;
        m_t = 0;
        m_a = mat_a_in;
        m_b = mat_b_in;
        m_f = (eng_da > eng_db) ? eng_da : eng_db;
        m_to = (eng_da == 0 || eng_db == 0 || m_f > TMO);
        if (m_to) m_f = TMO;
        m_v = m_to ? m_f + 2 : m_f + DRAIN + 2;
      end
    end else begin
      chk("job_start_ready", start_ready, 0);
      chk("job_busy", busy, 1);
      chk("job_tpu_clear", tpu_clear, (m_t == 0));
      chk("job_feed_rst", feed_rst, !(m_t >= 1 && m_t <= m_f));
      chk("job_result_valid", result_valid, (m_t >= m_v));
      chk("job_mat_a_out", mat_a_out, m_a);
      chk("job_mat_b_out", mat_b_out, m_b);
      if (m_t >= m_v) begin
        chk("out_result", result_out, m_to ? '0 : matmul(m_a, m_b));
        chk("out_err", result_err, m_to);
      end
      if (m_t >= m_v && result_ready) m_busy = 0;
      else m_t++;
    end
  end

  task automatic run_job(input logic [OW-1:0] a, input logic [OW-1:0] b,
                         input int da, input int db, input int hold,
                         output int lat, output logic err,
                         output logic [RW-1:0] res);
    int n;
    eng_da = da;
    eng_db = db;
    mat_a_in = a;
    mat_b_in = b;
    start_valid = 1'b1;
    n = 0;
    while (start_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("accept_wait", 0, 1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    mat_a_in = ~a;
    mat_b_in = ~b;
    n = 0;
    while (result_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("result_wait", 0, 1);
    lat = n;
    err = result_err;
    res = result_out;
    for (int i = 0; i < hold; i++) begin
      start_valid = i[0];
      @(posedge clk); #1;
      chk("bp_start_ready", start_ready, 0);
      chk("bp_valid", result_valid, 1);
      chk("bp_result", result_out, res);
    end
    start_valid = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  int lat, n;
  logic err;
  logic [RW-1:0] res;

  initial begin
    rst = 1'b1;
    start_valid = 1'b0;
    result_ready = 1'b0;
    mat_a_in = '0;
    mat_b_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    clr_cnt = 0;
    run_job(ident(1), seq8(1, 1), 10, 10, 0, lat, err, res);
    chk("nom_latency", lat, 16);
    chk("nom_err", err, 0);
    chk("nom_result", res, seq20(1, 1, 1));
    chk("nom_clear_cycles", clr_cnt, 1);

    run_job(ident(1), seq8(1, 1), 10, 13, 0, lat, err, res);
    chk("skew_latency", lat, 19);
    chk("skew_result", res, seq20(1, 1, 1));

    run_job(ident(1), seq8(1, 1), 10, 0, 0, lat, err, res);
    chk("tmo_latency", lat, 34);
    chk("tmo_err", err, 1);
    chk("tmo_result", res, 0);

    run_job(seq8(1, 1), seq8(16, -1), 10, 10, 20, lat, err, res);
    chk("bp_latency", lat, 16);
    chk("bp_err", err, 0);

    // Back-to-back with start_valid held and result_ready tied high
    eng_da = 10;
    eng_db = 10;
    result_ready = 1'b1;
    mat_a_in = ident(1);
    mat_b_in = seq8(16, -1);
    start_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b_accept1", busy, 1);
    mat_a_in = seq8(1, 1);
    mat_b_in = ident(1);
    n = 0;
    while (result_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("b2b_lat1", n, 16);
    chk("b2b_result1", result_out, seq20(16, -1, 1));
    @(posedge clk); #1;
    chk("b2b_idle_gap", start_ready, 1);
    @(posedge clk); #1;
    chk("b2b_accept2", tpu_clear, 1);
    n = 0;
    while (result_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    start_valid = 1'b0;
    chk("b2b_lat2", n, 16);
    chk("b2b_result2", result_out, seq20(1, 1, 1));
    @(posedge clk); #1;
    result_ready = 1'b0;
    @(posedge clk); #1;

    // Reset during FEED cycle 5
    mat_a_in = ident(3);
    mat_b_in = seq8(2, 1);
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_in_feed", feed_rst, 0);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_start_ready", start_ready, 1);
    chk("midrst_feed_rst", feed_rst, 1);
    chk("midrst_mat_a_out", mat_a_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_job(ident(2), seq8(1, 1), 10, 10, 0, lat, err, res);
    chk("post_rst_latency", lat, 16);
    chk("post_rst_result", res, seq20(1, 1, 2));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Top-level sequencer for one systolic matrix multiply.
- Accepts an operand pair (A, B) through a valid/ready handshake and latches both operands.
- Clears the PE accumulators, releases the A-row and B-column padding/skew engines, and waits for both engines to report done.
- Waits a fixed drain interval, captures the accumulator array, then presents the result through a valid/ready handshake.

Parameters:
MATRIX_SIZE, 4, matrix dimension N (N x N operands, N x N PE array)
DATA_WIDTH, 8, operand element width
ACC_WIDTH, 20, PE accumulator width per result element
DRAIN_CYCLES, 4, cycles allowed after feed completion for the last partial products to settle
FEED_TIMEOUT, 32, maximum FEED cycles before the job is aborted

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
start_valid  in  1  operand pair offered
start_ready  out  1  sequencer can accept a job
mat_a_in  in  N*N*DATA_WIDTH  flattened A, element [0][0] in MSBs
mat_b_in  in  N*N*DATA_WIDTH  flattened B, same packing as A
mat_a_out  out  N*N*DATA_WIDTH  latched A driven to the row padding engine
mat_b_out  out  N*N*DATA_WIDTH  latched B driven to the column padding engine
feed_rst  out  1  holds both padding engines in their initial state while high
feed_done_a  in  1  done pulse from the A padding engine
feed_done_b  in  1  done pulse from the B padding engine
tpu_clear  out  1  synchronous clear of all PE accumulators
tpu_result_in  in  N*N*ACC_WIDTH  accumulator array contents
result_out  out  N*N*ACC_WIDTH  captured result
result_valid  out  1  result_out is valid
result_ready  in  1  consumer accepts the result
result_err  out  1  qualifies result_valid; high when the job timed out
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values (asynchronous): state=IDLE, start_ready=1, feed_rst=1, tpu_clear=0, result_valid=0, result_err=0, busy=0, result_out=0, mat_a_out=0, mat_b_out=0, all counters and sticky flags cleared.
- A reset asserted mid-job aborts the job immediately and produces no result.
- All outputs are registered, driven directly from state or from registers.
- States and transitions:
  - IDLE: start_ready=1, feed_rst=1. On start_valid & start_ready, latch mat_a_in/mat_b_in into mat_a_out/mat_b_out, then go to CLEAR.
  - CLEAR: exactly 1 cycle. tpu_clear=1, feed_rst=1. Then go to FEED.
  - FEED: feed_rst=0. feed_cnt increments every cycle. done_a/done_b are sticky flags set by feed_done_a/feed_done_b; the pulses may arrive in different cycles. When both flags are set (including a same-cycle set), go to DRAIN. If feed_cnt reaches FEED_TIMEOUT-1 without both flags set, set err and go to CAPTURE, skipping DRAIN.
  - DRAIN: feed_rst=1, so the engines do not restart their sequence. Stays DRAIN_CYCLES cycles, then goes to CAPTURE.
  - CAPTURE: 1 cycle. result_out <= tpu_result_in; result_err <= err. Then go to OUT.
  - OUT: result_valid=1. result_out and result_err are held stable while result_ready=0. On result_ready, go to IDLE; the flags, counters and err clear on that transition.
- start_ready is 0 in every non-IDLE state. start_valid there is ignored and the operand registers are not disturbed.
- Nominal latency: the padding engines pulse done on their 10th cycle after feed_rst falls. With DRAIN_CYCLES=4, result_valid rises 16 clock edges after the accept edge (CLEAR 1 + FEED 10 + DRAIN 4 + CAPTURE 1).
- Back-to-back: a job offered in the cycle the sequencer returns to IDLE is accepted on the next edge. No bubble is required beyond the IDLE cycle.
- feed_done pulses received outside FEED are ignored.
- Widths: feed_cnt is $clog2(FEED_TIMEOUT) bits. The drain counter is $clog2(DRAIN_CYCLES+1) bits. Neither counter wraps; each is cleared on state entry.

Test Plan:
- Nominal: A=identity, B elements 1..16. Offer a job; model the engines as pulsing done on FEED cycle 10 -> result_valid at edge 16 after accept, result_out = B, result_err=0, tpu_clear high for exactly 1 cycle.
- Skewed done: feed_done_a on FEED cycle 10, feed_done_b on cycle 13 -> DRAIN entered after cycle 13, result_valid at edge 19.
- Timeout: feed_done_b never pulses -> CAPTURE after 32 FEED cycles, result_valid=1 with result_err=1, DRAIN skipped.
- Backpressure: hold result_ready=0 for 20 cycles -> result_valid and result_out stable; start_valid pulses in that window are not accepted (start_ready=0).
- Back-to-back: two jobs with start_valid held high, result_ready tied 1 -> both results correct, second accept occurs 1 cycle after the first result handshake.
- Reset mid-FEED: assert rst on FEED cycle 5 -> all outputs return to reset values immediately; the next job completes normally with correct data.
